// File: rtl/golden_nonce_uart_tx_if.sv
// golden_nonce_uart_tx_if: nonce push strobe from the hash core plus UART line and status outputs
interface golden_nonce_uart_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [31:0]                   golden_nonce;
    logic                          golden_nonce_match;
    logic                          txd;
    logic                          busy;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;

    modport master (
        output golden_nonce, golden_nonce_match,
        input  txd, busy, fifo_count, overflow
    );

    modport slave (
        input  golden_nonce, golden_nonce_match,
        output txd, busy, fifo_count, overflow
    );
endinterface

// File: rtl/golden_nonce_uart_tx.sv
// golden_nonce_uart_tx: FIFO-buffered UART 8N1 sender of golden nonces; define GOLDEN_TX_CHECKSUM_EN to append an XOR checksum byte
module golden_nonce_uart_tx #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 4
) (
    input logic                   hash_clk,
    input logic                   reset,
    golden_nonce_uart_tx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef GOLDEN_TX_CHECKSUM_EN
    localparam int FW = 40;
    localparam int BW = 3;
`else
    localparam int FW = 32;
    localparam int BW = 2;
`endif
    localparam logic [BW-1:0] LAST_BYTE = BW'(FW / 8 - 1);
    localparam logic [15:0]   BAUD_MAX  = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic [31:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [31:0]     head;
    logic [FW-1:0]   frame, frame_load;
    logic [15:0]     baud_cnt;
    logic [2:0]      bit_cnt;
    logic [BW-1:0]   byte_cnt;
    logic            txd, busy, overflow;
    logic            tick, empty, full, push, pop;

    assign head  = mem[rd_ptr];
    assign empty = count == '0;
    assign full  = count == (AW + 1)'(FIFO_DEPTH);
    assign tick  = baud_cnt == BAUD_MAX;
    assign push  = bus.golden_nonce_match && (!full || pop);

`ifdef GOLDEN_TX_CHECKSUM_EN
    assign frame_load = {head[31:24] ^ head[23:16] ^ head[15:8] ^ head[7:0], head};
`else
    assign frame_load = head;
`endif

    assign bus.txd        = txd;
    assign bus.busy       = busy;
    assign bus.fifo_count = count;
    assign bus.overflow   = overflow;

    // FIFO storage is not reset; only the pointers define what is valid
    always_ff @(posedge hash_clk) begin
        if (push) mem[wr_ptr] <= bus.golden_nonce;
    end

    // FIFO pointers, occupancy and the sticky drop flag
    always_ff @(posedge hash_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (bus.golden_nonce_match && full && !pop) overflow <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge hash_clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_next;
    end

    // next state; a pop happens when idle or at the end of a frame with work queued
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop        = 1'b1;
                state_next = START;
            end
            START: if (tick) state_next = DATA;
            DATA: if (tick && bit_cnt == 3'd7) state_next = STOP;
            STOP: if (tick) begin
                if (byte_cnt != LAST_BYTE) state_next = START;
                else if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end else state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // bit timing and the registered serial line
    always_ff @(posedge hash_clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            frame    <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
        end else begin
            baud_cnt <= (state == IDLE || tick) ? 16'd0 : baud_cnt + 16'd1;
            if (pop) begin
                frame    <= frame_load;
                byte_cnt <= '0;
                txd      <= 1'b0;
                busy     <= 1'b1;
            end else if (tick) begin
                case (state)
                    START: begin
                        bit_cnt <= 3'd0;
                        txd     <= frame[{byte_cnt, 3'd0}];
                    end
                    DATA: begin
                        if (bit_cnt == 3'd7) txd <= 1'b1;
                        else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= frame[{byte_cnt, bit_cnt + 3'd1}];
                        end
                    end
                    STOP: begin
                        if (byte_cnt != LAST_BYTE) begin
                            byte_cnt <= byte_cnt + 1'b1;
                            txd      <= 1'b0;
                        end else busy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/golden_nonce_uart_tx.md
Name: golden_nonce_uart_tx

Overview:
- Serial-comms consumer of the hash core's one-cycle golden_nonce_match strobe.
- Captures each golden_nonce into a small FIFO so no strobe is lost while the line is busy.
- Serialises each nonce as a UART 8N1 frame to the host.
- Sits between the hash core and the board's TX pin, in the hash_clk domain.

Parameters:
- BAUD_DIV, 868: hash_clk cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- FIFO_DEPTH, 4: nonce FIFO entries. Power of two, 2..16.

Ports:
- hash_clk  input  1  sole clock.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- golden_nonce  input  32  nonce from the hash core; valid only in a cycle where golden_nonce_match=1.
- golden_nonce_match  input  1  one-cycle push strobe.
- txd  output  1  UART serial out; idles high.
- busy  output  1  high while a frame is being shifted out.
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of FIFO entries held.
- overflow  output  1  sticky flag: a nonce was dropped.

Behaviour:
- Reset (reset=0), effective immediately, including mid-frame:
  - txd=1, busy=0, fifo_count=0, overflow=0.
  - FSM goes to IDLE; FIFO pointers, baud counter and bit counter are cleared.
  - The partial frame is abandoned and is not resent.
- Push: on a rising edge with golden_nonce_match=1 and the FIFO not full, golden_nonce is written.
- Full push: if the FIFO is full and no pop happens on the same edge, the nonce is dropped and overflow<=1. overflow clears only on reset.
- Simultaneous push and pop:
  - Both take effect and fifo_count is unchanged.
  - A push when full succeeds if a pop occurs on the same edge.
  - A push into an empty FIFO cannot pop on the same edge; the pop happens on the next edge.
- Frame format:
  - Bytes go least-significant first: nonce[7:0], [15:8], [23:16], [31:24].
  - Each byte is start bit (0), 8 data bits LSB first, stop bit (1).
  - Each bit lasts exactly BAUD_DIV cycles.
  - Bytes follow back-to-back with no idle gap.
  - 4 bytes = 40 bits = 40*BAUD_DIV cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START: on an edge in IDLE with the FIFO non-empty, pop the head into the shift register, set txd<=0 and busy<=1, reset the baud counter. txd therefore falls on the edge after the capture edge.
  - START -> DATA: after BAUD_DIV cycles; txd = bit0.
  - DATA: bits 0..7, each held BAUD_DIV cycles. After bit 7, go to STOP.
  - STOP: txd=1 for BAUD_DIV cycles.
  - Leaving STOP:
    - More bytes remain in the frame: go to START of the next byte.
    - Frame done and FIFO non-empty: pop and go to START on the same edge (no idle bit between frames).
    - Otherwise: IDLE with busy<=0.
- Baud counter: counts 0..BAUD_DIV-1 and wraps; a bit advances on the wrap.
- Byte counter: 0..3, or 0..4 with the option below.
- txd is driven directly from a register (glitch-free).
- golden_nonce is ignored whenever golden_nonce_match=0.

Optional Feature:
- Macro: GOLDEN_TX_CHECKSUM_EN.
- Defined:
  - A fifth byte, the XOR of the four nonce bytes, is appended after nonce[31:24].
  - Frame = 50 bits = 50*BAUD_DIV cycles.
  - Byte counter runs 0..4.
- Undefined: 4-byte frame only, and no checksum logic is synthesised.

Test Plan:
- Single nonce, BAUD_DIV=4, golden_nonce=0x12345678 strobed once:
  - txd falls one edge after the capture edge.
  - Decoded bytes are 0x78, 0x56, 0x34, 0x12.
  - busy is high for exactly 160 cycles, then txd=1, busy=0, fifo_count=0.
- Checksum, GOLDEN_TX_CHECKSUM_EN defined, same stimulus: bytes are 0x78, 0x56, 0x34, 0x12, 0x08; busy high for 200 cycles.
- Overflow, FIFO_DEPTH=4, strobes on 6 consecutive cycles with nonces 0..5:
  - Nonce 0 pops on the 2nd edge while nonce 1 pushes.
  - fifo_count peaks at 4; nonce 5 is dropped and overflow=1.
  - Nonces 0..4 are transmitted back-to-back with no idle bits.
- Push while full coinciding with the end-of-frame pop: the push is accepted, fifo_count stays at FIFO_DEPTH, overflow stays 0.
- Reset mid-frame: assert reset=0 during bit 3 of byte 2:
  - txd=1, busy=0, fifo_count=0 immediately, without waiting for a clock edge.
  - After release, the line stays idle until the next strobe.
- golden_nonce toggling with golden_nonce_match=0 for 100 cycles: no FIFO activity, txd stays 1.
